// File: rtl/wam_ctl.sv
// -----------------------------------------------------------------------------
// wam_ctl : whac-a-mole game sequencer
//
// Picks pseudo-random mole positions, times each mole window, turns switch
// toggles into one-cycle hit pulses and counts the game down in ticks.
//
// Ports
//   clk        system clock
//   clr        asynchronous active-high reset
//   start      button level; a rising edge starts or restarts a game
//   sw[7:0]    raw switch levels; any toggle is a tap
//   mole[7:0]  one-hot lit mole (LEDs), zero when none lit
//   hit[7:0]   one-cycle one-hot pulse on an effective hit
//   miss       one-cycle pulse when a window expires unhit
//   time_left  remaining game ticks (display)
//   state      IDLE=0, GAP=1, UP=2, OVER=3
// -----------------------------------------------------------------------------
module wam_ctl #(
    parameter int         TICK_DIV   = 50_000_000,
    parameter int         GAP_TICKS  = 2,
    parameter int         MOLE_TICKS = 3,
    parameter int         GAME_TICKS = 60,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] sw,
    output logic [7:0] mole,
    output logic [7:0] hit,
    output logic       miss,
    output logic [7:0] time_left,
    output logic [1:0] state
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int PH_MAX = (GAP_TICKS > MOLE_TICKS) ? GAP_TICKS : MOLE_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_GAP    = PH_W'(GAP_TICKS);
    localparam logic [PH_W-1:0]  PH_MOLE   = PH_W'(MOLE_TICKS);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [7:0]       GAME_LOAD = 8'(GAME_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t st, st_next;

    // Two synchroniser flops plus one edge-detect flop per input.
    logic [7:0] sw_m, sw_s, sw_d;
    logic       start_m, start_s, start_d;
    logic [7:0] tap;
    logic       start_edge;

    logic [CNT_W-1:0] cnt;
    logic             active, tick;
    logic [PH_W-1:0]  phase, phase_next;
    logic [7:0]       lfsr;
    logic [2:0]       pos, pos_next, cand, new_pos;

    logic do_restart, do_hit, do_over, do_up, do_miss;
    logic [7:0] mole_next, hit_next, time_next;
    logic       miss_next;

    assign tap        = sw_s ^ sw_d;
    assign start_edge = start_s & ~start_d;
    assign active     = (st == GAP) || (st == UP);
    assign tick       = active && (cnt == CNT_LAST);

    // Never repeat the previous position: bump a colliding candidate by one.
    assign cand    = lfsr[2:0];
    assign new_pos = (cand == pos) ? cand + 3'd1 : cand;

    assign state = st;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sw_m    <= '0;
            sw_s    <= '0;
            sw_d    <= '0;
            start_m <= 1'b0;
            start_s <= 1'b0;
            start_d <= 1'b0;
        end else begin
            sw_m    <= sw;
            sw_s    <= sw_m;
            sw_d    <= sw_s;
            start_m <= start;
            start_s <= start_m;
            start_d <= start_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) st <= IDLE;
        else     st <= st_next;
    end

    // Next-state logic; also flags which game event this cycle represents.
    // NOTE: every signal gets a default first so the combinational block can
    // never infer a latch.
    always_comb begin
        st_next    = st;
        do_restart = 1'b0;
        do_hit     = 1'b0;
        do_over    = 1'b0;
        do_up      = 1'b0;
        do_miss    = 1'b0;
        case (st)
            IDLE, OVER: begin
                if (start_edge) st_next = GAP;
            end
            GAP, UP: begin
                if (start_edge) begin
                    st_next    = GAP;
                    do_restart = 1'b1;
                end else begin
                    do_hit = (st == UP) && tap[pos];
                    // The final tick ends the game ahead of any phase change.
                    if (tick && (time_left == 8'd1)) begin
                        st_next = OVER;
                        do_over = 1'b1;
                    end else if (do_hit) begin
                        st_next = GAP;
                    end else if (tick && (phase == PH_ONE)) begin
                        if (st == GAP) begin
                            st_next = UP;
                            do_up   = 1'b1;
                        end else begin
                            st_next = GAP;
                            do_miss = 1'b1;
                        end
                    end
                end
            end
            default: st_next = IDLE;
        endcase
    end

    // Output / datapath next values, registered below.
    always_comb begin
        mole_next  = mole;
        hit_next   = '0;
        miss_next  = 1'b0;
        time_next  = time_left;
        phase_next = phase;
        pos_next   = pos;
        if (start_edge) begin
            // Fresh game load from any state; a running window is abandoned.
            mole_next  = '0;
            time_next  = GAME_LOAD;
            phase_next = PH_GAP;
        end else if (active) begin
            if (tick) time_next = time_left - 8'd1;
            if (do_hit) begin
                hit_next   = 8'b1 << pos;
                mole_next  = '0;
                phase_next = PH_GAP;
            end
            if (do_over) begin
                mole_next = '0;
            end else if (do_up) begin
                mole_next  = 8'b1 << new_pos;
                pos_next   = new_pos;
                phase_next = PH_MOLE;
            end else if (do_miss) begin
                miss_next  = 1'b1;
                mole_next  = '0;
                phase_next = PH_GAP;
            end else if (tick && !do_hit) begin
                phase_next = phase - PH_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mole      <= '0;
            hit       <= '0;
            miss      <= 1'b0;
            time_left <= '0;
            phase     <= '0;
            pos       <= '0;
            lfsr      <= LFSR_SEED;
            cnt       <= '0;
        end else begin
            mole      <= mole_next;
            hit       <= hit_next;
            miss      <= miss_next;
            time_left <= time_next;
            phase     <= phase_next;
            pos       <= pos_next;
            // Fibonacci LFSR, taps 8,6,5,4; free-running in every state.
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            // Any state change or restart realigns the tick grid.
            if ((st_next != st) || do_restart || tick) cnt <= '0;
            else if (active)                           cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wam_ctl.sv
// -----------------------------------------------------------------------------
// tb_wam_ctl : self-checking bench for wam_ctl
//
// A cycle-level behavioural model of the game rules runs beside the DUT and
// every output is compared each cycle; directed phases hit the corner cases,
// then a randomized phase plays many games.
// -----------------------------------------------------------------------------
module tb_wam_ctl;

    localparam int         TD   = 4;
    localparam int         GT   = 1;
    localparam int         MT   = 2;
    localparam int         GAME = 6;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] sw;
    logic [7:0] mole, hit, time_left;
    logic       miss;
    logic [1:0] state;

    wam_ctl #(
        .TICK_DIV  (TD),
        .GAP_TICKS (GT),
        .MOLE_TICKS(MT),
        .GAME_TICKS(GAME),
        .LFSR_SEED (SEED)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .sw       (sw),
        .mole     (mole),
        .hit      (hit),
        .miss     (miss),
        .time_left(time_left),
        .state    (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 idle, 1 gap, 2 up, 3 over.
    int         m_state, m_time, m_phase, m_cnt;
    logic [2:0] m_pos;
    logic [7:0] m_lfsr, m_mole, m_hit;
    logic       m_miss;
    logic [7:0] sw_q [3];
    logic       st_q [3];
    bit         entered_up;
    int         windows = 0;
    logic [7:0] prev_mole;

    task automatic model_reset();
        m_state = 0; m_time = 0; m_phase = 0; m_cnt = 0;
        m_pos = 3'd0; m_lfsr = SEED; m_mole = 8'h00; m_hit = 8'h00; m_miss = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw_q[i] = 8'h00;
            st_q[i] = 1'b0;
        end
        entered_up = 1'b0;
        prev_mole  = 8'h01;   // last position resets to 0
    endtask

    task automatic model_step();
        logic [7:0] tap;
        logic       st_edge, tick, hit_now, final_t;
        logic [2:0] cand, np;
        int         old_state;
        bit         restart;
        tap     = sw_q[1] ^ sw_q[2];
        st_edge = st_q[1] & ~st_q[2];
        tick    = (m_state == 1 || m_state == 2) && (m_cnt == TD - 1);
        cand    = m_lfsr[2:0];
        np      = (cand == m_pos) ? cand + 3'd1 : cand;
        old_state  = m_state;
        restart    = 1'b0;
        m_hit      = 8'h00;
        m_miss     = 1'b0;
        entered_up = 1'b0;
        if (m_state == 0 || m_state == 3) begin
            if (st_edge) begin
                m_state = 1; m_time = GAME; m_phase = GT;
            end
        end else if (st_edge) begin
            restart = 1'b1;
            m_state = 1; m_time = GAME; m_phase = GT; m_mole = 8'h00;
        end else begin
            hit_now = (m_state == 2) && tap[m_pos];
            final_t = tick && (m_time == 1);
            if (hit_now) begin
                m_hit  = 8'b1 << m_pos;
                m_mole = 8'h00;
            end
            if (tick) m_time = m_time - 1;
            if (final_t) begin
                m_state = 3;
                m_mole  = 8'h00;
            end else if (hit_now) begin
                m_state = 1;
                m_phase = GT;
            end else if (tick) begin
                m_phase = m_phase - 1;
                if (m_phase == 0) begin
                    if (m_state == 1) begin
                        m_state = 2; m_pos = np; m_mole = 8'b1 << np; m_phase = MT;
                        entered_up = 1'b1;
                        windows++;
                    end else begin
                        m_miss = 1'b1; m_mole = 8'h00; m_state = 1; m_phase = GT;
                    end
                end
            end
        end
        if (m_state != old_state || restart)   m_cnt = 0;
        else if (m_state == 1 || m_state == 2) m_cnt = tick ? 0 : m_cnt + 1;
        m_lfsr  = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        sw_q[2] = sw_q[1]; sw_q[1] = sw_q[0]; sw_q[0] = sw;
        st_q[2] = st_q[1]; st_q[1] = st_q[0]; st_q[0] = start;
    endtask

    task automatic compare_all();
        check("state", state, m_state);
        check("mole", mole, m_mole);
        check("hit", hit, m_hit);
        check("miss", miss, m_miss);
        check("time_left", time_left, m_time);
        if (entered_up) begin
            check("no_repeat_pos", (mole != prev_mole), 1);
            prev_mole = mole;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (clr) model_reset();
        else     model_step();
        #1;
        compare_all();
    endtask

    function automatic bit model_match(input int ws, input int wp, input int wc, input int wt);
        return (m_state == ws) && (wp < 0 || m_phase == wp) &&
               (wc < 0 || m_cnt == wc) && (wt < 0 || m_time == wt);
    endfunction

    task automatic wait_until(input string tag, input int ws, input int wp,
                              input int wc, input int wt, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (model_match(ws, wp, wc, wt)) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        if (!found) found = model_match(ws, wp, wc, wt);
        check({"wait_", tag}, found, 1);
    endtask

    task automatic restart_game();
        start = 1'b0;
        repeat (3) cycle();
        start = 1'b1;
        repeat (3) cycle();
        check("restart_time", time_left, GAME);
        check("restart_state", state, 1);
    endtask

    task automatic toggle(input logic [2:0] idx);
        sw[idx] = ~sw[idx];
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] exp_hit;
        logic [2:0] unlit;
        int         k;
        bit         got;

        clr = 1'b0; start = 1'b0; sw = 8'h00;
        #1 clr = 1'b1;
        #1 model_reset();
        compare_all();
        repeat (2) cycle();
        clr = 1'b0;

        // Start, then hit the lit mole: pulse 3 clk after the toggle.
        start = 1'b1;
        wait_until("first_up", 2, -1, -1, -1, 50);
        exp_hit = 8'b1 << m_pos;
        toggle(m_pos);
        repeat (3) cycle();
        check("hit_pulse", hit, exp_hit);
        cycle();
        check("hit_once", hit, 0);
        check("after_hit_mole", mole, 0);
        check("after_hit_state", state, 1);

        // Untapped window: miss 8 clk after UP entry; unlit taps ignored.
        restart_game();
        wait_until("miss_up", 2, -1, -1, -1, 50);
        unlit = m_pos + 3'd3;
        k = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (i == 1) toggle(unlit);
            cycle();
            k++;
            if (miss) got = 1'b1;
        end
        check("miss_latency", k, 8);
        check("miss_hit_clear", hit, 0);

        // Run out the game untouched; last tick also ends a window.
        wait_until("game_over", 3, -1, -1, -1, 100);
        check("over_time", time_left, 0);
        check("over_mole", mole, 0);

        // Tap landing on the expiry tick, then on the final tick.
        restart_game();
        wait_until("expiry_tap", 2, 1, TD - 3, -1, 60);
        exp_hit = 8'b1 << m_pos;
        toggle(m_pos);
        repeat (3) cycle();
        check("expiry_hit", hit, exp_hit);
        check("expiry_no_miss", miss, 0);
        wait_until("final_tap", 2, 1, TD - 3, -1, 60);
        exp_hit = 8'b1 << m_pos;
        toggle(m_pos);
        repeat (3) cycle();
        check("final_hit", hit, exp_hit);
        check("final_over", state, 3);

        // Restart in UP with time_left == 3.
        restart_game();
        start = 1'b0;
        wait_until("r_up", 2, -1, -1, -1, 50);
        toggle(m_pos);
        wait_until("r_gap", 1, -1, -1, -1, 10);
        wait_until("r_up3", 2, -1, -1, 3, 60);
        start = 1'b1;
        repeat (3) cycle();
        check("rs_time", time_left, GAME);
        check("rs_state", state, 1);
        check("rs_mole", mole, 0);
        check("rs_hit", hit, 0);
        check("rs_miss", miss, 0);

        // Asynchronous reset in the middle of a window.
        wait_until("rst_up", 2, -1, -1, -1, 50);
        cycle();
        clr = 1'b1;
        #1 model_reset();
        compare_all();
        repeat (2) cycle();
        start = 1'b0;
        clr   = 1'b0;

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            if (m_state == 0 || m_state == 3) start = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 299) == 0) start = ~start;
            if ($urandom_range(0, 9) == 0) toggle(3'($urandom_range(0, 7)));
            if (m_state == 2 && $urandom_range(0, 5) == 0) toggle(m_pos);
            cycle();
        end
        check("windows_seen", (windows >= 16), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
